apb_req_arbiter: RTL
====================

Name: apb_req_arbiter

Overview:
- Round-robin APB master that shares one APB slave port, such as the team's 256-entry APB memory, between NUM_REQ local requesters.
- Each requester uses a simple req/done handshake. The block sequences the APB SETUP and ACCESS phases, waits for pready, and returns read data.
- Sits between the requesting engines and the APB slave in the APB UVC testbench and SoC fabric.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with APB_ARB_TIMEOUT_EN

Ports:
pclk  in  1  APB clock
rst_n  in  1  reset, asynchronous, active-low
req  in  NUM_REQ  per-requester transfer request, level
req_write  in  NUM_REQ  per-requester direction, 1=write
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing
done  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data; valid while done is high
rsp_err  out  1  error flag; valid while done is high
paddr  out  ADDR_WIDTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready

Behaviour:
- Reset, asynchronous and effective immediately, including mid-transfer:
  - state=IDLE.
  - psel, penable, pwrite, paddr, pwdata, done, rsp_rdata and rsp_err are all 0.
  - last_gnt=NUM_REQ-1, so requester 0 has top priority after reset.
  - An in-flight transfer is dropped silently; no done pulse is issued.
- State IDLE:
  - If done!=0 in this cycle, do not arbitrate. This blanking cycle gives the requester time to drop req.
  - Otherwise, if any req is high, grant the first set bit searching upward from last_gnt+1 with wrap-around.
  - On grant, latch that requester's addr, write and wdata into paddr, pwrite and pwdata. Set psel=1, penable=0 and go to SETUP.
- State SETUP: lasts exactly one cycle. Set penable=1 and go to ACCESS.
- State ACCESS, held until pready=1:
  - On the pready=1 edge: psel=0, penable=0, done[gnt]=1 for one cycle, last_gnt=gnt, go to IDLE.
  - For a read, rsp_rdata captures prdata. For a write, rsp_rdata is left unchanged.
- APB outputs: paddr, pwrite and pwdata stay stable from SETUP until the end of ACCESS.
- Latency, zero wait states: req sampled at edge k → psel at k+1, penable at k+2, done at k+3. Each wait state adds one cycle.
- Minimum spacing between transfers is 2 idle cycles: the done cycle plus the blanking rule.
- Requester rules:
  - Hold req, addr, write and wdata stable until done is seen.
  - Deassert req no later than the cycle after done; otherwise it is treated as a new request.
  - If req drops mid-transfer, the transfer still completes and done still pulses.
- Fairness: a requester that holds req is served within NUM_REQ transfers.
- Requester address and data changes after grant are ignored.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - If it reaches TIMEOUT_CYCLES, the transfer aborts: psel=0, penable=0, done[gnt]=1, rsp_err=1, rsp_rdata=0, last_gnt advances, go to IDLE.
  - A pready arriving on the same edge as the limit wins: normal completion, rsp_err=0.
- When undefined: no counter, rsp_err is tied 0, and ACCESS waits indefinitely.

Test Plan:
- Requester 0 writes addr 0x10, data 0xDEADBEEF, with pready=1 → psel at k+1, penable at k+2, done=4'b0001 at k+3, pwrite=1, pwdata=0xDEADBEEF; psel is never asserted again while req is low.
- Requester 2 reads addr 0x05 with pready held low 2 cycles and prdata=0x05 → ACCESS lasts 3 cycles, paddr is stable throughout, done=4'b0100 and rsp_rdata=0x05 together.
- req=4'b1010 held continuously after reset → grant order is 1, 3, 1, 3, with 2 idle cycles between each psel deassert and the next assert.
- req=4'b1111 for 8 transfers → grant order is 0, 1, 2, 3, 0, 1, 2, 3 and no requester is starved.
- rst_n pulsed low during ACCESS of requester 1 → psel, penable and done drop immediately with no done pulse; after release, requester 0 is granted first.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held low → done=1 with rsp_err=1 and rsp_rdata=0 at ACCESS cycle 16; next grant goes to the following requester.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin APB master. NUM_REQ local requesters share one
// APB slave port through a req/done handshake. The block grants one request,
// runs the APB SETUP/ACCESS phases, waits for pready, and returns read data.
//
// Build option: define APB_ARB_TIMEOUT_EN to bound the ACCESS phase at
// TIMEOUT_CYCLES wait cycles. An expired transfer completes with rsp_err=1.
// Without the macro, ACCESS waits for pready indefinitely and rsp_err is 0.
module apb_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          pclk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pready
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state;
    logic [GW-1:0]       last_gnt;
    logic [GW-1:0]       gnt;
    logic [GW-1:0]       pick;
    logic                pick_valid;
    logic [GW-1:0]       cand [NUM_REQ];
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    // Unpack the flattened requester buses and precompute the search order:
    // cand[k] is the requester checked k-th, starting just after last_gnt.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign cand[gi]      = GW'((int'(last_gnt) + gi + 1) % NUM_REQ);
    end

    // Round-robin pick: first requesting index upward from last_gnt+1, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_valid && req[cand[k]]) begin
                pick_valid = 1'b1;
                pick       = cand[k];
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    logic          err_q;
    assign rsp_err = err_q;
`else
    // The timeout parameter only has an effect in the timeout build.
    assign rsp_err = (TIMEOUT_CYCLES < 0);
`endif

    // Transfer sequencer: arbitration, APB phase control and response capture.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            done      <= '0;
            rsp_rdata <= '0;
            last_gnt  <= GW'(NUM_REQ - 1);
            gnt       <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    // A done pulse this cycle blanks arbitration so the
                    // finished requester has a cycle to drop req.
                    if (done == '0 && pick_valid) begin
                        gnt     <= pick;
                        paddr   <= addr_arr[pick];
                        pwrite  <= req_write[pick];
                        pwdata  <= wdata_arr[pick];
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        done[gnt] <= 1'b1;
                        last_gnt  <= gnt;
                        if (!pwrite) begin
                            rsp_rdata <= prdata;
                        end
`ifdef APB_ARB_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                        state <= IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    // The counter holds the number of completed wait cycles,
                    // so the abort fires at the end of ACCESS cycle TIMEOUT_CYCLES.
                    else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        done[gnt] <= 1'b1;
                        last_gnt  <= gnt;
                        rsp_rdata <= '0;
                        err_q     <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
